alu_pipe: RTL



---
 rtl/alu_pipe.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides, a multi-cycle shift-add
// multiplier and an internal accumulator. Single-cycle ops produce a result on the edge
// after accept; multiply produces its result WIDTH edges after accept.
module alu_pipe #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       fxn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] answer,
  output logic             carry,
  output logic             o_flow,
  output logic             err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned Msb  = WIDTH - 1;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  localparam logic [3:0] FnPass = 4'h0;
  localparam logic [3:0] FnAdd  = 4'h1;
  localparam logic [3:0] FnSub  = 4'h2;
  localparam logic [3:0] FnNeg  = 4'h3;
  localparam logic [3:0] FnSlt  = 4'h4;
  localparam logic [3:0] FnAnd  = 4'h5;
  localparam logic [3:0] FnXor  = 4'h6;
  localparam logic [3:0] FnAsr  = 4'h7;
  localparam logic [3:0] FnMul  = 4'h8;
  localparam logic [3:0] FnAcc  = 4'h9;
  localparam logic [3:0] FnClr  = 4'hA;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   answer_q;
  logic               carry_q;
  logic               o_flow_q;
  logic               err_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CntW-1:0]    cnt_q;

  // Next-state values for a single-cycle op
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             o_flow_d;
  logic             err_d;
  logic [WIDTH-1:0] acc_d;

  logic               accept;
  logic               consume;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH:0]     acc_sum_ext;
  logic signed [WIDTH-1:0] x_s;
  logic signed [WIDTH-1:0] y_s;
  logic [WIDTH-1:0]   asr_small;
  logic               shift_big;
  logic [2*WIDTH-1:0] prod_step;
  logic               mul_last;

  assign in_ready  = (state_q == StIdle) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign answer    = answer_q;
  assign carry     = carry_q;
  assign o_flow    = o_flow_q;
  assign err       = err_q;

  assign sum_ext     = {1'b0, x} + {1'b0, y};
  assign diff_ext    = {1'b0, x} - {1'b0, y};
  assign acc_sum_ext = {1'b0, acc_q} + {1'b0, x};
  assign x_s         = x;
  assign y_s         = y;
  // Shift amounts of WIDTH or more saturate to a full sign fill
  assign shift_big   = {1'b0, y} >= (WIDTH + 1)'(WIDTH);
  assign asr_small   = x_s >>> y;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last  = (cnt_q == CntW'(WIDTH - 1));

  // Decode the function code into result, flags and accumulator update
  always_comb begin
    res_d    = '0;
    carry_d  = 1'b0;
    o_flow_d = 1'b0;
    err_d    = 1'b0;
    acc_d    = acc_q;
    case (fxn)
      FnPass: res_d = x;
      FnAdd: begin
        res_d    = sum_ext[WIDTH-1:0];
        carry_d  = sum_ext[WIDTH];
        o_flow_d = (x[Msb] == y[Msb]) & (sum_ext[Msb] != x[Msb]);
      end
      FnSub: begin
        res_d    = diff_ext[WIDTH-1:0];
        carry_d  = diff_ext[WIDTH];
        o_flow_d = (x[Msb] != y[Msb]) & (diff_ext[Msb] != x[Msb]);
      end
      FnNeg: begin
        res_d    = -x;
        o_flow_d = (x == MinNeg);
      end
      FnSlt: res_d = {{(WIDTH - 1){1'b0}}, (x_s < y_s)};
      FnAnd: res_d = x & y;
      FnXor: res_d = x ^ y;
      FnAsr: res_d = shift_big ? {WIDTH{x[Msb]}} : asr_small;
      FnAcc: begin
        res_d    = acc_sum_ext[WIDTH-1:0];
        carry_d  = acc_sum_ext[WIDTH];
        o_flow_d = (acc_q[Msb] == x[Msb]) & (acc_sum_ext[Msb] != acc_q[Msb]);
        acc_d    = acc_sum_ext[WIDTH-1:0];
      end
      FnClr: begin
        res_d = '0;
        acc_d = '0;
      end
      default: err_d = 1'b1;
    endcase
  end

  // Control FSM, output registers, accumulator and multiplier datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      answer_q    <= '0;
      carry_q     <= 1'b0;
      o_flow_q    <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (fxn == FnMul) begin
              // Output slot is free or consumed on this edge, so it is empty during MUL
              state_q     <= StMul;
              mcand_q     <= {{WIDTH{1'b0}}, x};
              mplier_q    <= y;
              prod_q      <= '0;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
            end else begin
              answer_q    <= res_d;
              carry_q     <= carry_d;
              o_flow_q    <= o_flow_d;
              err_q       <= err_d;
              acc_q       <= acc_d;
              out_valid_q <= 1'b1;
            end
          end else if (consume) begin
            out_valid_q <= 1'b0;
          end
        end
        StMul: begin
          prod_q   <= prod_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (mul_last) begin
            answer_q    <= prod_step[WIDTH-1:0];
            carry_q     <= |prod_step[2*WIDTH-1:WIDTH];
            o_flow_q    <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
